fact_responder: RTL and testbench

- Memory-mapped factorial accelerator on the data-memory side of the pipelined MIPS core.
- Responds to the core's M-stage data-memory accesses: write enable, word address, write data and read data.
- Software loads n and pulses GO, then polls STATUS and reads RESULT.
- An iterative multiply FSM computes n! without stalling the core.

---
 rtl/fact_responder.sv | 193 +++++++++++++++++++
 tb/tb_fact_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fact_responder.sv
// -----------------------------------------------------------------------------
// fact_responder
//   Memory-mapped factorial accelerator on the data-memory side of the core.
//   Software writes n, pulses GO, polls STATUS and reads RESULT. The product is
//   built by an iterative multiply that runs in the background, so the core is
//   never stalled.
//
//   Register map (word index on addr):
//     0 N       rw  operand n (N_W bits, zero-extended on read)
//     1 GO      w   wd[0] = 1 starts a computation; reads 0
//     2 STATUS  r   {.., busy, err, done}; wd[0] = 1 clears irq (FACT_IRQ_EN)
//     3 RESULT  r   last completed n! (0 after an out-of-range request)
//
//   Ports:
//     clk   core clock, rising edge
//     rst   asynchronous active-low reset
//     sel   address decoder select for this block
//     we    write strobe, qualified by sel
//     addr  word index
//     wd    write data
//     rd    combinational read data (0 when sel is low)
//     irq   level done interrupt, only built with FACT_IRQ_EN
//
//   Build option:
//     FACT_IRQ_EN  adds the sticky done interrupt and the STATUS write clear.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for GO; result and flags hold their last values
//   CALC  | one multiply step per cycle, cnt counts down from n to 1
// -----------------------------------------------------------------------------
module fact_responder #(
  parameter int DATA_W = 32,
  parameter int N_W    = 4,
  parameter int MAX_N  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd
`ifdef FACT_IRQ_EN
  ,
  output logic              irq
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam logic [N_W-1:0]    MAX_N_C = N_W'(MAX_N);
  localparam logic [N_W-1:0]    ONE_N   = N_W'(1);
  localparam logic [DATA_W-1:0] ONE_D   = DATA_W'(1);

  state_t              state_q, state_d;
  logic [N_W-1:0]      n_q, n_d;
  logic [N_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                busy;
  logic                wr_n;
  logic                go_acc;
  logic                done_set;
  logic [DATA_W-1:0]   cnt_ext;

  assign busy    = (state_q == CALC);
  assign wr_n    = sel & we & (addr == 2'd0) & ~busy;
  assign go_acc  = sel & we & (addr == 2'd1) & wd[0] & ~busy;
  assign cnt_ext = DATA_W'(cnt_q);

  // Only the low N_W bits of wd (and bit 0 for GO/STATUS) carry meaning.
  logic unused_wd;
  assign unused_wd = ^wd[DATA_W-1:N_W];

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    res_d    = res_q;
    done_d   = done_q;
    err_d    = err_q;
    done_set = 1'b0;

    if (wr_n) begin
      n_d = wd[N_W-1:0];
    end

    case (state_q)
      IDLE: begin
        if (go_acc) begin
          done_d = 1'b0;
          err_d  = 1'b0;
          if (n_q > MAX_N_C) begin
            // Out-of-range request completes at once with an error flag.
            err_d    = 1'b1;
            done_d   = 1'b1;
            res_d    = '0;
            done_set = 1'b1;
          end else begin
            acc_d   = ONE_D;
            cnt_d   = n_q;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // cnt <= 1 also covers n = 0, giving 0! = 1 after a single cycle.
        if (cnt_q <= ONE_N) begin
          res_d    = acc_q;
          done_d   = 1'b1;
          done_set = 1'b1;
          state_d  = IDLE;
        end else begin
          acc_d = acc_q * cnt_ext;
          cnt_d = cnt_q - ONE_N;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef FACT_IRQ_EN
  logic irq_q, irq_d;
  logic irq_clr;

  assign irq_clr = (sel & we & (addr == 2'd2) & wd[0]) | go_acc;

  // Completion wins over a clear in the same cycle, so an error GO still
  // leaves the interrupt raised.
  always_comb begin
    irq_d = irq_q;
    if (done_set) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rd = '0;
    if (sel) begin
      case (addr)
        2'd0:    rd = DATA_W'(n_q);
        2'd1:    rd = '0;
        2'd2:    rd = {{(DATA_W-3){1'b0}}, busy, err_q, done_q};
        2'd3:    rd = res_q;
        default: rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_responder.sv
module tb_fact_responder;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        sel  = 1'b0;
  logic        we   = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wd   = 32'd0;
  logic [31:0] rd;
`ifdef FACT_IRQ_EN
  logic        irq;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fact_responder #(
    .DATA_W(32),
    .N_W   (4),
    .MAX_N (12)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sel (sel),
    .we  (we),
    .addr(addr),
    .wd  (wd),
    .rd  (rd)
`ifdef FACT_IRQ_EN
    ,
    .irq (irq)
`endif
  );

  // Reference: n! by plain arithmetic, 0 for requests above 12.
  function automatic logic [31:0] ref_fact(input int n);
    longint p;
    p = 1;
    if (n > 12) return 32'd0;
    for (int i = 2; i <= n; i++) p = p * i;
    return p[31:0];
  endfunction

  // Cycles from the GO edge to the completing edge.
  function automatic int ref_lat(input int n);
    if (n > 12) return 0;
    if (n < 1) return 1;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] v);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    #1;
    v   = rd;
    sel = 1'b0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    sel  = 1'b1;
    we   = 1'b1;
    addr = a;
    wd   = d;
    @(posedge clk);
    #1;
    sel = 1'b0;
    we  = 1'b0;
    wd  = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(input int n, input bit inj_n, input bit inj_go, input bit clr_irq);
    logic [31:0] v;
    logic [31:0] exp_status;
    logic [31:0] exp_res;
    int          lat;
    int          n2;

    wr_reg(2'd0, ($urandom & 32'hFFFF_FFF0) | 32'(n));
    rd_reg(2'd0, v);
    check("n_readback", v, 32'(n));

    lat     = ref_lat(n);
    exp_res = ref_fact(n);
    wr_reg(2'd1, 32'h1 | ($urandom & 32'hFFFF_FFFE));

    for (int c = 0; c <= lat; c++) begin
      if (c >= lat) exp_status = (n > 12) ? 32'h3 : 32'h1;
      else          exp_status = 32'h4;
      rd_reg(2'd2, v);
      check("status_seq", v, exp_status);
`ifdef FACT_IRQ_EN
      check("irq_seq", {31'd0, irq}, {31'd0, (c >= lat)});
`endif
      if (c < lat) begin
        if (c == 1 && inj_n)       wr_reg(2'd0, $urandom);
        else if (c == 2 && inj_go) wr_reg(2'd1, 32'h1);
        else                       step();
      end
    end

    rd_reg(2'd3, v);
    check("result", v, exp_res);
    rd_reg(2'd0, v);
    check("n_hold", v, 32'(n));

    // Idle no-ops: GO with bit0 clear, RESULT write, write without select.
    wr_reg(2'd1, $urandom & 32'hFFFF_FFFE);
    wr_reg(2'd3, $urandom);
    @(negedge clk);
    sel  = 1'b0;
    we   = 1'b1;
    addr = 2'd0;
    wd   = 32'h9;
    step();
    we = 1'b0;
    wd = 32'd0;
    rd_reg(2'd2, v);
    check("status_noop", v, (n > 12) ? 32'h3 : 32'h1);
    rd_reg(2'd3, v);
    check("result_noop", v, exp_res);
    rd_reg(2'd0, v);
    check("n_noop", v, 32'(n));

    if (clr_irq) begin
      wr_reg(2'd2, 32'h1);
      rd_reg(2'd2, v);
      check("status_after_clr", v, (n > 12) ? 32'h3 : 32'h1);
`ifdef FACT_IRQ_EN
      check("irq_cleared", {31'd0, irq}, 32'd0);
`endif
    end

    // A new N leaves result and flags alone.
    n2 = $urandom_range(0, 15);
    wr_reg(2'd0, 32'(n2));
    rd_reg(2'd3, v);
    check("result_after_n", v, exp_res);
    rd_reg(2'd2, v);
    check("status_after_n", v, (n > 12) ? 32'h3 : 32'h1);
  endtask

  initial begin
    logic [31:0] v;

    #3;
    rd_reg(2'd0, v);
    check("rst_n", v, 32'd0);
    rd_reg(2'd2, v);
    check("rst_status", v, 32'd0);
    rd_reg(2'd3, v);
    check("rst_result", v, 32'd0);
`ifdef FACT_IRQ_EN
    check("rst_irq", {31'd0, irq}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    run_case(5, 1'b0, 1'b0, 1'b1);
    sel  = 1'b0;
    addr = 2'd3;
    #1;
    check("sel_low_rd", rd, 32'd0);

    run_case(12, 1'b0, 1'b0, 1'b0);
    run_case(13, 1'b0, 1'b0, 1'b0);
    run_case(0,  1'b0, 1'b0, 1'b1);
    run_case(1,  1'b0, 1'b0, 1'b0);
    run_case(6,  1'b1, 1'b1, 1'b1);
    run_case(3,  1'b0, 1'b0, 1'b1);

    for (int t = 0; t < 25; t++) begin
      run_case($urandom_range(0, 15), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Asynchronous reset in the middle of a 5! computation.
    wr_reg(2'd0, 32'd5);
    wr_reg(2'd1, 32'd1);
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    rd_reg(2'd2, v);
    check("midrst_status", v, 32'd0);
    rd_reg(2'd3, v);
    check("midrst_result", v, 32'd0);
`ifdef FACT_IRQ_EN
    check("midrst_irq", {31'd0, irq}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    rd_reg(2'd0, v);
    check("postrst_n", v, 32'd0);
    rd_reg(2'd2, v);
    check("postrst_status", v, 32'd0);
    rd_reg(2'd3, v);
    check("postrst_result", v, 32'd0);

    run_case(7, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
